adc_frontend: RTL and testbench
===============================

Name: adc_frontend

Overview:
- Front-end conditioning stage directly upstream of the receiver.
- Captures raw offset-binary ADC words and the ADC over-range pin, then converts them to signed two's complement.
- Optionally inverts polarity and removes DC with a first-order leaky integrator.
- Drives the signed adc_data / adc_ovfl pair consumed by the receiver's RX/WF channels and level/overflow detectors; also provides a ramp test-pattern mode and a post-config settle (mute) interval.

Parameters:
- ADC_BITS, 14, raw and output sample width.
- SETTLE_CYCLES, 1024, mute interval after reset or cfg_load; legal range 1..65535.
- ACC_EXT, 15, extra fractional bits in the DC accumulator (the maximum dc shift).

Ports:
- adc_clk  in  1  sample clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- adc_raw  in  ADC_BITS  raw ADC word, offset binary.
- adc_or  in  1  ADC over-range pin, aligned with adc_raw.
- cfg_load  in  1  one-cycle strobe, already synchronised to adc_clk.
- cfg_word  in  7  [0] dc_en, [1] invert, [2] ramp, [6:3] dc_k shift.
- adc_data  out  ADC_BITS  signed conditioned sample.
- adc_ovfl  out  1  per-sample overflow.
- adc_valid  out  1  high in RUN state.
- dc_est  out  ADC_BITS  current DC estimate, signed.

Behaviour:
- Clock and reset: one clock, adc_clk; reset rst is asynchronous, active-high.
- Reset values: all pipeline registers 0, accumulator 0, cfg register 0 (dc_en=0, invert=0, ramp=0, k=1), ramp counter 0, state SETTLE with settle counter 0, all outputs 0.
- Config: cfg_word is latched on cfg_load. dc_k=0 is treated as 1; k is limited to ACC_EXT.
- Pipeline, fixed latency 3:
  - S1 registers adc_raw and adc_or.
  - S2 forms x = {~raw[MSB], raw[MSB-1:0]} as signed. If invert, x = -x, widened to ADC_BITS+1 bits.
  - S2 computes y = x - dc (ADC_BITS+2 bits), where dc = acc >>> k (arithmetic).
  - S3 saturates y to [-2^(ADC_BITS-1), 2^(ADC_BITS-1)-1]. sat_hit = clipping occurred.
  - S3 sets adc_ovfl = S2 over-range | sat_hit.
- Result: a sample presented before edge n appears on the outputs after edge n+3.
- DC accumulator:
  - Signed, ADC_BITS+ACC_EXT+1 bits.
  - Every clock with dc_en=1 and ramp=0: acc <= acc + x - dc.
  - dc_en=0: acc held at 0, so dc=0.
  - Accumulator is not cleared on cfg_load when dc_en stays 1; only k changes.
  - dc_est = dc truncated and saturated to ADC_BITS.
- Ramp mode:
  - A signed ADC_BITS counter increments every clock and wraps +max -> -min.
  - It replaces S2 y; invert and DC are bypassed, acc holds its value, adc_ovfl = 0.
  - Counter resets to 0 on cfg_load.
- State machine, SETTLE / RUN:
  - SETTLE: adc_data=0, adc_ovfl=0, adc_valid=0. The pipeline and accumulator keep running. Counter increments each clock.
  - SETTLE -> RUN on the clock the counter reaches SETTLE_CYCLES-1.
  - RUN -> SETTLE on cfg_load; counter cleared.
  - cfg_load while in SETTLE restarts the count at 0.
  - In RUN, outputs follow S3 every clock.
- cfg_load and a sample in flight: the new cfg applies to S2 from the clock after the strobe. Samples already in S3 are muted because the state is SETTLE.
- Async reset mid-stream: outputs go to 0 immediately, without waiting for a clock edge; the block resumes via the full SETTLE interval.

Test Plan:
- Reset release, adc_raw=0x3FFF, default cfg -> adc_valid=0 and adc_data=0 for exactly 1024 clocks, then adc_valid=1 and adc_data=8191 (0x1FFF).
- In RUN, step adc_raw 0x2000 -> 0x0000 -> 0x3FFF on consecutive clocks -> adc_data 0, -8192, 8191 appear 3 clocks after each input; adc_or pulse on the 0x0000 sample -> adc_ovfl high on that output only.
- cfg dc_en=1, k=4, constant adc_raw=0x2000+100 -> dc_est monotonically rises to 100 ±1 within 400 clocks; adc_data decays from 100 to 0 ±1.
- cfg invert=1, dc_en=0, adc_raw=0x0000 -> adc_data=+8191, adc_ovfl=1 (saturation); adc_raw=0x2001 -> adc_data=-1, adc_ovfl=0.
- cfg ramp=1 -> after settle, adc_data increments by 1 per clock and wraps 8191 -> -8192; adc_ovfl stays 0 with adc_or held high.
- cfg_load issued at settle count 1000, then again at 500 -> adc_valid stays low until 1024 clocks after the last strobe; rst asserted mid-RUN -> outputs 0 asynchronously, and adc_valid returns after 1024 clocks.

Source files
------------

// File: rtl/adc_frontend.sv
// ADC front end: offset-binary capture, signed conversion, optional inversion,
// leaky-integrator DC removal, ramp test pattern and a post-config mute interval.
module adc_frontend #(
  parameter int ADC_BITS      = 14,
  parameter int SETTLE_CYCLES = 1024,
  parameter int ACC_EXT       = 15
) (
  input  logic                adc_clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] adc_raw,
  input  logic                adc_or,
  input  logic                cfg_load,
  input  logic [6:0]          cfg_word,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                adc_ovfl,
  output logic                adc_valid,
  output logic [ADC_BITS-1:0] dc_est
);
  localparam int XW = ADC_BITS + 1;
  localparam int YW = ADC_BITS + 2;
  localparam int AW = ADC_BITS + ACC_EXT + 1;
  localparam int KW = $clog2(ACC_EXT + 1);

  typedef enum logic {SETTLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                dc_en_q, dc_en_d, inv_q, inv_d, ramp_en_q, ramp_en_d;
  logic [KW-1:0]       k_q, k_d;
  logic [ADC_BITS-1:0] raw1_q, raw1_d;
  logic                or1_q, or1_d, or2_q, or2_d, ovfl3_q, ovfl3_d;
  logic [YW-1:0]       y2_q, y2_d;
  logic [ADC_BITS-1:0] data3_q, data3_d, ramp_q, ramp_d;
  logic [AW-1:0]       acc_q, acc_d;

  logic [ADC_BITS-1:0] x_off;
  logic [XW-1:0]       x;
  logic [AW-1:0]       dc;
  logic [YW-1:0]       y;
  logic                y_clip, dc_clip;

  always_comb begin
    dc_en_d   = dc_en_q;
    inv_d     = inv_q;
    ramp_en_d = ramp_en_q;
    k_d       = k_q;
    if (cfg_load) begin
      dc_en_d   = cfg_word[0];
      inv_d     = cfg_word[1];
      ramp_en_d = cfg_word[2];
      if (cfg_word[6:3] == 4'd0)
        k_d = KW'(1);
      else if (int'(cfg_word[6:3]) > ACC_EXT)
        k_d = KW'(ACC_EXT);
      else
        k_d = KW'(cfg_word[6:3]);
    end

    raw1_d = adc_raw;
    or1_d  = adc_or;

    // Offset binary to two's complement is a flip of the MSB.
    x_off = {~raw1_q[ADC_BITS-1], raw1_q[ADC_BITS-2:0]};
    x     = {x_off[ADC_BITS-1], x_off};
    if (inv_q) x = -x;
    dc = $signed(acc_q) >>> k_q;
    y  = {x[XW-1], x} - dc[YW-1:0];

    y2_d  = ramp_en_q ? {{2{ramp_q[ADC_BITS-1]}}, ramp_q} : y;
    or2_d = or1_q & ~ramp_en_q;

    acc_d = acc_q;
    if (!dc_en_q)
      acc_d = '0;
    else if (!ramp_en_q)
      acc_d = acc_q + {{(AW-XW){x[XW-1]}}, x} - dc;

    // Out of range when the bits above the output sign are not all copies of it.
    y_clip  = ~(&y2_q[YW-1:ADC_BITS-1]) & (|y2_q[YW-1:ADC_BITS-1]);
    data3_d = y_clip ? {y2_q[YW-1], {(ADC_BITS-1){~y2_q[YW-1]}}} : y2_q[ADC_BITS-1:0];
    ovfl3_d = or2_q | y_clip;

    dc_clip = ~(&dc[AW-1:ADC_BITS-1]) & (|dc[AW-1:ADC_BITS-1]);
    dc_est  = dc_clip ? {dc[AW-1], {(ADC_BITS-1){~dc[AW-1]}}} : dc[ADC_BITS-1:0];

    ramp_d = cfg_load ? '0 : ramp_q + ADC_BITS'(1);

    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_load) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_q == 16'(SETTLE_CYCLES - 1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end

    adc_valid = (state_q == RUN);
    adc_data  = adc_valid ? data3_q : '0;
    adc_ovfl  = adc_valid & ovfl3_q;
  end

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_q   <= SETTLE;
      cnt_q     <= '0;
      dc_en_q   <= 1'b0;
      inv_q     <= 1'b0;
      ramp_en_q <= 1'b0;
      k_q       <= KW'(1);
      raw1_q    <= '0;
      or1_q     <= 1'b0;
      y2_q      <= '0;
      or2_q     <= 1'b0;
      data3_q   <= '0;
      ovfl3_q   <= 1'b0;
      acc_q     <= '0;
      ramp_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dc_en_q   <= dc_en_d;
      inv_q     <= inv_d;
      ramp_en_q <= ramp_en_d;
      k_q       <= k_d;
      raw1_q    <= raw1_d;
      or1_q     <= or1_d;
      y2_q      <= y2_d;
      or2_q     <= or2_d;
      data3_q   <= data3_d;
      ovfl3_q   <= ovfl3_d;
      acc_q     <= acc_d;
      ramp_q    <= ramp_d;
    end
  end
endmodule

// File: tb/tb_adc_frontend.sv
// Bench for adc_frontend: integer reference model of the conditioning chain,
// directed scenarios followed by randomized config/sample segments.
module tb_adc_frontend;
  localparam int B  = 14;
  localparam int SC = 1024;
  localparam int AE = 15;
  localparam int MAXV = 8191;
  localparam int MINV = -8192;

  logic         adc_clk = 1'b0;
  logic         rst = 1'b1;
  logic [B-1:0] adc_raw = '0;
  logic         adc_or = 1'b0;
  logic         cfg_load = 1'b0;
  logic [6:0]   cfg_word = '0;
  logic [B-1:0] adc_data, dc_est;
  logic         adc_ovfl, adc_valid;

  adc_frontend #(.ADC_BITS(B), .SETTLE_CYCLES(SC), .ACC_EXT(AE)) dut (
    .adc_clk(adc_clk), .rst(rst), .adc_raw(adc_raw), .adc_or(adc_or),
    .cfg_load(cfg_load), .cfg_word(cfg_word), .adc_data(adc_data),
    .adc_ovfl(adc_ovfl), .adc_valid(adc_valid), .dc_est(dc_est)
  );

  always #5 adc_clk = ~adc_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic, samples tracked per stage.
  int     m_s1_raw, m_s1_or, m_or2, m_d3, m_o3, m_ramp, m_since;
  longint m_y2, m_acc;
  int     c_dc, c_inv, c_ramp, c_k;

  function automatic longint clipv(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic model_reset();
    m_s1_raw = 0; m_s1_or = 0; m_y2 = 0; m_or2 = 0; m_d3 = 0; m_o3 = 0;
    m_ramp = 0; m_since = 0; m_acc = 0;
    c_dc = 0; c_inv = 0; c_ramp = 0; c_k = 1;
  endtask

  task automatic model_edge();
    longint x, dc, ny2;
    int nd3, no3, nor2;
    nd3 = int'(clipv(m_y2));
    no3 = (m_or2 != 0 || nd3 != m_y2) ? 1 : 0;
    x = longint'(m_s1_raw) - 8192;
    if (c_inv != 0) x = -x;
    dc = m_acc >>> c_k;
    ny2  = (c_ramp != 0) ? longint'(m_ramp) : x - dc;
    nor2 = (c_ramp != 0) ? 0 : m_s1_or;
    if (c_dc == 0) m_acc = 0;
    else if (c_ramp == 0) m_acc = m_acc + x - dc;
    if (cfg_load) m_ramp = 0;
    else m_ramp = (m_ramp == MAXV) ? MINV : m_ramp + 1;
    m_d3 = nd3; m_o3 = no3; m_y2 = ny2; m_or2 = nor2;
    m_s1_raw = int'(adc_raw); m_s1_or = int'(adc_or);
    if (cfg_load) begin
      c_dc = int'(cfg_word[0]); c_inv = int'(cfg_word[1]); c_ramp = int'(cfg_word[2]);
      c_k = int'(cfg_word[6:3]);
      if (c_k == 0) c_k = 1;
      if (c_k > AE) c_k = AE;
      m_since = 0;
    end else if (m_since < SC) begin
      m_since++;
    end
  endtask

  task automatic check_outputs(input string pfx);
    int v;
    v = (m_since >= SC) ? 1 : 0;
    chk({pfx, "_valid"}, int'(adc_valid), v);
    chk({pfx, "_data"}, int'($signed(adc_data)), v ? m_d3 : 0);
    chk({pfx, "_ovfl"}, int'(adc_ovfl), v ? m_o3 : 0);
    chk({pfx, "_dcest"}, int'($signed(dc_est)), int'(clipv(m_acc >>> c_k)));
  endtask

  task automatic tick();
    @(posedge adc_clk);
    model_edge();
    #1;
    check_outputs("cyc");
  endtask

  task automatic load_cfg(input logic [6:0] w);
    cfg_word = w;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic run_until_valid(output int n, input int limit);
    n = 0;
    while (!adc_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  int first, n, prev, mono, wrapped, ok, pv;
  int pd[1:6];
  int po[1:6];

  initial begin
    // Reset state and settle interval with full-scale input.
    adc_raw = 14'h3FFF;
    model_reset();
    #12;
    check_outputs("rst");
    @(negedge adc_clk);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (adc_valid && first == 0) first = i;
    end
    chk("settle_len", first, 1024);
    chk("fullscale", int'($signed(adc_data)), 8191);

    // Mid-scale, negative full scale with over-range, positive full scale.
    adc_raw = 14'h2000; adc_or = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      pd[i] = int'($signed(adc_data));
      po[i] = int'(adc_ovfl);
      if (i == 1) begin adc_raw = 14'h0000; adc_or = 1'b1; end
      if (i == 2) begin adc_raw = 14'h3FFF; adc_or = 1'b0; end
    end
    chk("step_mid", pd[3], 0);
    chk("step_mid_ovfl", po[3], 0);
    chk("step_neg", pd[4], -8192);
    chk("step_neg_ovfl", po[4], 1);
    chk("step_pos", pd[5], 8191);
    chk("step_pos_ovfl", po[5], 0);

    // DC removal, k=4, constant +100 offset.
    adc_raw = 14'(16'h2000 + 16'd100);
    load_cfg({4'd4, 1'b0, 1'b0, 1'b1});
    mono = 1; prev = 0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (int'($signed(dc_est)) < prev) mono = 0;
      prev = int'($signed(dc_est));
      if (i == 400) begin
        ok = (prev >= 99 && prev <= 101) ? 1 : 0;
        chk("dc_conv", ok, 1);
      end
    end
    chk("dc_mono", mono, 1);
    ok = ($signed(adc_data) >= -1 && $signed(adc_data) <= 1) ? 1 : 0;
    chk("dc_removed", ok, 1);

    // Inversion without DC removal.
    adc_raw = 14'h0000;
    load_cfg(7'b0000010);
    repeat (1030) tick();
    chk("inv_sat", int'($signed(adc_data)), 8191);
    chk("inv_sat_ovfl", int'(adc_ovfl), 1);
    adc_raw = 14'h2001;
    repeat (3) tick();
    chk("inv_m1", int'($signed(adc_data)), -1);
    chk("inv_m1_ovfl", int'(adc_ovfl), 0);

    // Ramp with over-range held high.
    adc_or = 1'b1;
    load_cfg(7'b0000100);
    wrapped = 0; ok = 1; pv = 0;
    for (int i = 1; i <= 9300; i++) begin
      tick();
      if (adc_valid && pv != 0) begin
        if (prev == MAXV && int'($signed(adc_data)) == MINV) wrapped = 1;
        else if (int'($signed(adc_data)) != prev + 1) ok = 0;
        if (adc_ovfl) ok = 0;
      end
      pv = int'(adc_valid);
      prev = int'($signed(adc_data));
    end
    chk("ramp_wrap", wrapped, 1);
    chk("ramp_step", ok, 1);
    adc_or = 1'b0;

    // Repeated strobes during settle restart the interval.
    load_cfg(7'b0000000);
    repeat (1000) tick();
    load_cfg(7'b0000000);
    repeat (500) tick();
    chk("restart_low", int'(adc_valid), 0);
    load_cfg(7'b0000000);
    run_until_valid(n, 2000);
    chk("restart_len", n, 1024);

    // Asynchronous reset in RUN.
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge adc_clk);
    rst = 1'b0;
    run_until_valid(n, 2000);
    chk("rst_settle_len", n, 1024);

    // Randomized config segments and samples.
    for (int s = 0; s < 12; s++) begin
      logic [6:0] w;
      load_cfg(7'b0000000);
      w = 7'($urandom);
      if (($urandom % 4) != 0) w[2] = 1'b0;
      load_cfg(w);
      repeat (1100 + $urandom_range(0, 150)) begin
        adc_raw = B'($urandom);
        adc_or = (($urandom % 8) == 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
